// File: rtl/nios_system_nios2_div_cell.sv
// Multi-cycle 32-bit radix-2 restoring divider (div/divu) for the Nios II M-stage.
// Fixed 33-cycle latency: 32 CALC iterations plus one FIXUP cycle that registers the results.
module nios_system_nios2_div_cell (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        M_div_start,
  input  logic        M_div_signed,
  input  logic [31:0] M_div_src1,
  input  logic [31:0] M_div_src2,
  output logic        M_div_busy,
  output logic        M_div_done,
  output logic [31:0] M_div_cell_result,
  output logic [31:0] M_div_cell_remainder
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        load;
  logic        step;
  logic        fix;

  logic        q_neg;
  logic        r_neg;
  logic [4:0]  count;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;

  logic [31:0] mag1;
  logic [31:0] mag2;
  logic [32:0] rem_sh;
  logic [32:0] trial;
  logic        trial_ok;

  // The most negative operand maps to itself, which reads correctly as unsigned 2^31.
  assign mag1 = (M_div_signed && M_div_src1[31]) ? (32'd0 - M_div_src1) : M_div_src1;
  assign mag2 = (M_div_signed && M_div_src2[31]) ? (32'd0 - M_div_src2) : M_div_src2;

  // The kept remainder is always below the divisor, so 32 bits of storage suffice;
  // only the shifted value and the trial difference need the 33rd bit.
  assign rem_sh   = {rem, quo[31]};
  assign trial    = rem_sh - {1'b0, dvs};
  assign trial_ok = ~trial[32];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    fix       = 1'b0;
    case (state)
      IDLE: begin
        if (M_div_start) begin
          load      = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (count == 5'd31) begin
          state_nxt = FIXUP;
        end
      end
      FIXUP: begin
        fix       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_neg                <= 1'b0;
      r_neg                <= 1'b0;
      count                <= 5'd0;
      rem                  <= 32'd0;
      quo                  <= 32'd0;
      dvs                  <= 32'd0;
      M_div_done           <= 1'b0;
      M_div_cell_result    <= 32'd0;
      M_div_cell_remainder <= 32'd0;
    end else begin
      M_div_done <= fix;
      if (load) begin
        q_neg <= M_div_signed & (M_div_src1[31] ^ M_div_src2[31]);
        r_neg <= M_div_signed & M_div_src1[31];
        quo   <= mag1;
        dvs   <= mag2;
        rem   <= 32'd0;
        count <= 5'd0;
      end
      if (step) begin
        rem   <= trial_ok ? trial[31:0] : rem_sh[31:0];
        quo   <= {quo[30:0], trial_ok};
        count <= count + 5'd1;
      end
      if (fix) begin
        M_div_cell_result    <= q_neg ? (32'd0 - quo) : quo;
        M_div_cell_remainder <= r_neg ? (32'd0 - rem) : rem;
      end
    end
  end

  assign M_div_busy = (state != IDLE);

endmodule

// File: tb/tb_nios_system_nios2_div_cell.sv
// Self-checking bench for the divider: directed literal cases plus a randomized
// regression compared every cycle against an arithmetic reference model.
module tb_nios_system_nios2_div_cell;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        M_div_start = 1'b0;
  logic        M_div_signed = 1'b0;
  logic [31:0] M_div_src1 = 32'd0;
  logic [31:0] M_div_src2 = 32'd0;
  logic        M_div_busy;
  logic        M_div_done;
  logic [31:0] M_div_cell_result;
  logic [31:0] M_div_cell_remainder;

  nios_system_nios2_div_cell dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .M_div_start          (M_div_start),
    .M_div_signed         (M_div_signed),
    .M_div_src1           (M_div_src1),
    .M_div_src2           (M_div_src2),
    .M_div_busy           (M_div_busy),
    .M_div_done           (M_div_done),
    .M_div_cell_result    (M_div_cell_result),
    .M_div_cell_remainder (M_div_cell_remainder)
  );

  // clock / cycle counter
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // reference model state: one outstanding division, results visible after done
  bit          act    = 1'b0;
  int          s_edge = 0;
  logic [31:0] cur_q  = 32'd0;
  logic [31:0] cur_r  = 32'd0;
  logic [31:0] pend_q = 32'd0;
  logic [31:0] pend_r = 32'd0;
  logic [31:0] pend_a = 32'd0;
  logic [31:0] pend_b = 32'd0;
  logic [31:0] exp_q[$];
  logic        exp_busy;
  logic        exp_done;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    longint sa;
    longint sb;
    longint q;
    longint r;
    if (b == 32'd0) begin
      if (sgn && a[31]) return {32'h0000_0001, a};
      return {32'hFFFF_FFFF, a};
    end
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {q[31:0], r[31:0]};
  endfunction

  // compare process: every cycle, outputs against the model
  always @(negedge clk) begin
    exp_busy = act && ((cyc - s_edge) <= 32);
    exp_done = act && ((cyc - s_edge) == 33);
    if (exp_done) begin
      cur_q = exp_q.pop_front();
      cur_r = pend_r;
    end
    check("busy", {31'd0, M_div_busy}, {31'd0, exp_busy});
    check("done", {31'd0, M_div_done}, {31'd0, exp_done});
    check("quotient", M_div_cell_result, cur_q);
    check("remainder", M_div_cell_remainder, cur_r);
    if (exp_done && M_div_done && pend_b != 32'd0)
      check("identity", M_div_cell_result * pend_b + M_div_cell_remainder, pend_a);
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [63:0] res;
    M_div_src1   = a;
    M_div_src2   = b;
    M_div_signed = sgn;
    M_div_start  = 1'b1;
    if (reset_n && (!act || (cyc - s_edge) >= 33)) begin
      res    = ref_div(a, b, sgn);
      exp_q.delete();
      exp_q.push_back(res[63:32]);
      pend_q = res[63:32];
      pend_r = res[31:0];
      pend_a = a;
      pend_b = b;
      act    = 1'b1;
      s_edge = cyc + 1;
    end
    tick();
    M_div_start = 1'b0;
  endtask

  task automatic wait_model_done();
    while (act && (cyc - s_edge) < 33) tick();
  endtask

  task automatic run_lit(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [31:0] eq, input logic [31:0] er);
    int n;
    pulse_start(a, b, sgn);
    n = 0;
    while (!M_div_done && n < 40) begin
      tick();
      n++;
    end
    check({name, "_latency"}, n, 33);
    check({name, "_q"}, M_div_cell_result, eq);
    check({name, "_r"}, M_div_cell_remainder, er);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      5:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dones;
    repeat (2) tick();
    check("reset_q", M_div_cell_result, 32'd0);
    check("reset_r", M_div_cell_remainder, 32'd0);
    check("reset_busy", {31'd0, M_div_busy}, 32'd0);
    reset_n = 1'b1;
    tick();

    // consecutive run_lit calls start in the previous done cycle
    run_lit("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
    run_lit("s_m100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
    run_lit("s100_m7", 32'd100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2);
    run_lit("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
    run_lit("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0);
    run_lit("u5_0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5);
    run_lit("s_m5_0", 32'hFFFF_FFFB, 32'd0, 1'b1, 32'h0000_0001, 32'hFFFF_FFFB);

    // a second start while busy must be ignored
    tick();
    pulse_start(32'd100, 32'd7, 1'b0);
    repeat (8) tick();
    pulse_start(32'd3, 32'd1, 1'b0);
    wait_model_done();
    check("ignore_q", M_div_cell_result, 32'd14);
    check("ignore_r", M_div_cell_remainder, 32'd2);
    dones = 0;
    repeat (40) begin
      tick();
      if (M_div_done) dones++;
    end
    check("ignore_extra_done", dones, 0);

    // asynchronous reset in the middle of a division
    pulse_start(32'd1000, 32'd3, 1'b0);
    repeat (14) tick();
    reset_n = 1'b0;
    act     = 1'b0;
    cur_q   = 32'd0;
    cur_r   = 32'd0;
    #1;
    check("midreset_q", M_div_cell_result, 32'd0);
    check("midreset_r", M_div_cell_remainder, 32'd0);
    check("midreset_busy", {31'd0, M_div_busy}, 32'd0);
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    run_lit("after_reset_9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0);

    // randomized regression, mixing gaps, done-cycle restarts and ignored starts
    for (int i = 0; i < 1500; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      pulse_start(pick(), pick(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 25)) tick();
        pulse_start(pick(), pick(), 1'($urandom_range(0, 1)));
      end
      wait_model_done();
    end

    repeat (40) tick();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
